// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and constants for the rv32i pipeline.
//   state_e    : ID/EX stage state (RUN, LD_WAIT)
//   ex_ctrl_t  : decoded control bundle carried from decode into execute
//   EX_BUBBLE  : all-zero control bundle (no write, no memory access)
//   ALU_*      : alu_control encodings shared with the control unit
package rv32i_pkg;

  localparam int ALU_CTRL_W = 4;
  localparam int FUN3_W     = 3;

  typedef enum logic {
    RUN     = 1'b0,
    LD_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic                  reg_write;
    logic                  operand_a;
    logic                  operand_b;
    logic                  load;
    logic                  store;
    logic                  branch;
    logic                  next_sel;
    logic                  jalr;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [1:0]            mem_to_reg;
    logic [FUN3_W-1:0]     fun3;
    logic [4:0]            rd;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_BUBBLE = '0;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b1001;

endpackage

// File: rtl/stall_counter.sv
// stall_counter: saturating up-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count this edge
//   count      : current value, sticks at all-ones
module stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the rv32i pipeline.
//   clk, rst_n          : clock, asynchronous active-low reset
//   *_i                 : decoded control bits and operands from decode
//   flush_i             : kill the instruction currently in decode
//   dm_valid_i          : data memory has returned the load data
//   *_o                 : execute-stage copies of the *_i fields
//   stall_o             : freeze PC and IF/ID register
//   decode_ppload_o     : a load is in flight in EX (also the state bit)
//   stall_cnt_o         : saturating count of stall cycles
//
// Handshake: a captured load moves the stage to LD_WAIT and raises
// decode_ppload_o. The stage then holds until dm_valid_i is seen high;
// stall_o = !dm_valid_i while waiting, so a cycle with dm_valid_i = 1
// is the cycle in which the next instruction is accepted on the edge.
import rv32i_pkg::*;

module id_ex_stage #(
  parameter int DATA_W      = 32,
  parameter int ALU_CONTROL = 4,
  parameter int FUNCTION3   = 3,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   reg_write_i,
  input  logic                   operand_a_i,
  input  logic                   operand_b_i,
  input  logic                   load_i,
  input  logic                   store_i,
  input  logic                   branch_i,
  input  logic                   next_sel_i,
  input  logic                   jalr_i,
  input  logic [ALU_CONTROL-1:0] alu_control_i,
  input  logic [1:0]             mem_to_reg_i,
  input  logic [FUNCTION3-1:0]   fun3_i,
  input  logic [4:0]             rd_i,
  input  logic [DATA_W-1:0]      pc_i,
  input  logic [DATA_W-1:0]      rs1_data_i,
  input  logic [DATA_W-1:0]      rs2_data_i,
  input  logic [DATA_W-1:0]      imm_i,
  input  logic                   flush_i,
  input  logic                   dm_valid_i,
  output logic                   reg_write_o,
  output logic                   operand_a_o,
  output logic                   operand_b_o,
  output logic                   load_o,
  output logic                   store_o,
  output logic                   branch_o,
  output logic                   next_sel_o,
  output logic                   jalr_o,
  output logic [ALU_CONTROL-1:0] alu_control_o,
  output logic [1:0]             mem_to_reg_o,
  output logic [FUNCTION3-1:0]   fun3_o,
  output logic [4:0]             rd_o,
  output logic [DATA_W-1:0]      pc_o,
  output logic [DATA_W-1:0]      rs1_data_o,
  output logic [DATA_W-1:0]      rs2_data_o,
  output logic [DATA_W-1:0]      imm_o,
  output logic                   stall_o,
  output logic                   decode_ppload_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  state_e            state_q, state_d;
  logic              flush_pend_q, flush_pend_d;
  ex_ctrl_t          ctrl_q, ctrl_in;
  logic [DATA_W-1:0] pc_q, rs1_q, rs2_q, imm_q;
  logic              capture;
  logic              kill;

  // Control bundle widths are fixed by the package; the size casts
  // adapt the module parameters to the shared struct layout.
  always_comb begin
    ctrl_in             = EX_BUBBLE;
    ctrl_in.reg_write   = reg_write_i;
    ctrl_in.operand_a   = operand_a_i;
    ctrl_in.operand_b   = operand_b_i;
    ctrl_in.load        = load_i;
    ctrl_in.store       = store_i;
    ctrl_in.branch      = branch_i;
    ctrl_in.next_sel    = next_sel_i;
    ctrl_in.jalr        = jalr_i;
    ctrl_in.alu_control = ALU_CTRL_W'(alu_control_i);
    ctrl_in.mem_to_reg  = mem_to_reg_i;
    ctrl_in.fun3        = FUN3_W'(fun3_i);
    ctrl_in.rd          = rd_i;
  end

  // In RUN the register always advances; in LD_WAIT only once the data
  // memory answers. flush_pend_q can only be set while waiting, so it
  // remembers a flush that arrived during the stall.
  always_comb begin
    capture      = (state_q == RUN) || dm_valid_i;
    kill         = flush_i || flush_pend_q;
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    if (capture) begin
      state_d      = (load_i && !kill) ? LD_WAIT : RUN;
      flush_pend_d = 1'b0;
    end else if (flush_i) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
      ctrl_q       <= EX_BUBBLE;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      imm_q        <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      if (capture) begin
        ctrl_q <= kill ? EX_BUBBLE : ctrl_in;
        pc_q   <= kill ? '0 : pc_i;
        rs1_q  <= kill ? '0 : rs1_data_i;
        rs2_q  <= kill ? '0 : rs2_data_i;
        imm_q  <= kill ? '0 : imm_i;
      end
    end
  end

  assign stall_o         = (state_q == LD_WAIT) && !dm_valid_i;
  assign decode_ppload_o = (state_q == LD_WAIT);

  assign reg_write_o   = ctrl_q.reg_write;
  assign operand_a_o   = ctrl_q.operand_a;
  assign operand_b_o   = ctrl_q.operand_b;
  assign load_o        = ctrl_q.load;
  assign store_o       = ctrl_q.store;
  assign branch_o      = ctrl_q.branch;
  assign next_sel_o    = ctrl_q.next_sel;
  assign jalr_o        = ctrl_q.jalr;
  assign alu_control_o = ALU_CONTROL'(ctrl_q.alu_control);
  assign mem_to_reg_o  = ctrl_q.mem_to_reg;
  assign fun3_o        = FUNCTION3'(ctrl_q.fun3);
  assign rd_o          = ctrl_q.rd;
  assign pc_o          = pc_q;
  assign rs1_data_o    = rs1_q;
  assign rs2_data_o    = rs2_q;
  assign imm_o         = imm_q;

  stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_o),
    .count (stall_cnt_o)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed stimulus for id_ex_stage with a
// cycle-level reference model and an expected-value queue. Two instances
// share the inputs: the default one and one with a 4-bit stall counter
// so that saturation is reachable.
module tb_id_ex_stage;

  localparam int CW = 22;                 // control bundle bits
  localparam int DW = 128;                // pc, rs1, rs2, imm
  localparam int SW = CW + DW + 1 + 1 + 16 + 4;

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n   = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          flush   = 1'b0;
  logic          dm      = 1'b0;

  // main instance outputs
  logic        reg_write_o, operand_a_o, operand_b_o, load_o, store_o;
  logic        branch_o, next_sel_o, jalr_o, stall_o, decode_ppload_o;
  logic [3:0]  alu_control_o;
  logic [1:0]  mem_to_reg_o;
  logic [2:0]  fun3_o;
  logic [4:0]  rd_o;
  logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [15:0] stall_cnt_o;

  // 4-bit counter instance outputs
  logic        s_reg_write, s_operand_a, s_operand_b, s_load, s_store;
  logic        s_branch, s_next_sel, s_jalr, s_stall, s_ppload;
  logic [3:0]  s_alu_control;
  logic [1:0]  s_mem_to_reg;
  logic [2:0]  s_fun3;
  logic [4:0]  s_rd;
  logic [31:0] s_pc, s_rs1, s_rs2, s_imm;
  logic [3:0]  s_cnt;

  id_ex_stage u_dut (
    .clk(clk), .rst_n(rst_n),
    .reg_write_i(in_ctrl[21]), .operand_a_i(in_ctrl[20]), .operand_b_i(in_ctrl[19]),
    .load_i(in_ctrl[18]), .store_i(in_ctrl[17]), .branch_i(in_ctrl[16]),
    .next_sel_i(in_ctrl[15]), .jalr_i(in_ctrl[14]), .alu_control_i(in_ctrl[13:10]),
    .mem_to_reg_i(in_ctrl[9:8]), .fun3_i(in_ctrl[7:5]), .rd_i(in_ctrl[4:0]),
    .pc_i(in_data[127:96]), .rs1_data_i(in_data[95:64]), .rs2_data_i(in_data[63:32]),
    .imm_i(in_data[31:0]), .flush_i(flush), .dm_valid_i(dm),
    .reg_write_o(reg_write_o), .operand_a_o(operand_a_o), .operand_b_o(operand_b_o),
    .load_o(load_o), .store_o(store_o), .branch_o(branch_o), .next_sel_o(next_sel_o),
    .jalr_o(jalr_o), .alu_control_o(alu_control_o), .mem_to_reg_o(mem_to_reg_o),
    .fun3_o(fun3_o), .rd_o(rd_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o),
    .rs2_data_o(rs2_data_o), .imm_o(imm_o), .stall_o(stall_o),
    .decode_ppload_o(decode_ppload_o), .stall_cnt_o(stall_cnt_o)
  );

  id_ex_stage #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .reg_write_i(in_ctrl[21]), .operand_a_i(in_ctrl[20]), .operand_b_i(in_ctrl[19]),
    .load_i(in_ctrl[18]), .store_i(in_ctrl[17]), .branch_i(in_ctrl[16]),
    .next_sel_i(in_ctrl[15]), .jalr_i(in_ctrl[14]), .alu_control_i(in_ctrl[13:10]),
    .mem_to_reg_i(in_ctrl[9:8]), .fun3_i(in_ctrl[7:5]), .rd_i(in_ctrl[4:0]),
    .pc_i(in_data[127:96]), .rs1_data_i(in_data[95:64]), .rs2_data_i(in_data[63:32]),
    .imm_i(in_data[31:0]), .flush_i(flush), .dm_valid_i(dm),
    .reg_write_o(s_reg_write), .operand_a_o(s_operand_a), .operand_b_o(s_operand_b),
    .load_o(s_load), .store_o(s_store), .branch_o(s_branch), .next_sel_o(s_next_sel),
    .jalr_o(s_jalr), .alu_control_o(s_alu_control), .mem_to_reg_o(s_mem_to_reg),
    .fun3_o(s_fun3), .rd_o(s_rd), .pc_o(s_pc), .rs1_data_o(s_rs1),
    .rs2_data_o(s_rs2), .imm_o(s_imm), .stall_o(s_stall),
    .decode_ppload_o(s_ppload), .stall_cnt_o(s_cnt)
  );

  logic [CW-1:0] out_ctrl, s_ctrl;
  logic [DW-1:0] out_data, s_data;
  assign out_ctrl = {reg_write_o, operand_a_o, operand_b_o, load_o, store_o, branch_o,
                     next_sel_o, jalr_o, alu_control_o, mem_to_reg_o, fun3_o, rd_o};
  assign out_data = {pc_o, rs1_data_o, rs2_data_o, imm_o};
  assign s_ctrl   = {s_reg_write, s_operand_a, s_operand_b, s_load, s_store, s_branch,
                     s_next_sel, s_jalr, s_alu_control, s_mem_to_reg, s_fun3, s_rd};
  assign s_data   = {s_pc, s_rs1, s_rs2, s_imm};

  // scoreboard
  logic [SW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected snapshot per cycle, compared mid-cycle.
  always @(negedge clk) begin
    logic [SW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ex_ctrl",    DW'(out_ctrl),        DW'(e[171:150]));
      check("ex_data",    out_data,             e[149:22]);
      check("stall",      DW'(stall_o),         DW'(e[21]));
      check("ppload",     DW'(decode_ppload_o), DW'(e[20]));
      check("stall_cnt",  DW'(stall_cnt_o),     DW'(e[19:4]));
      check("sat_ctrl",   DW'(s_ctrl),          DW'(e[171:150]));
      check("sat_data",   s_data,               e[149:22]);
      check("sat_stall",  DW'(s_stall),         DW'(e[21]));
      check("sat_ppload", DW'(s_ppload),        DW'(e[20]));
      check("sat_cnt",    DW'(s_cnt),           DW'(e[3:0]));
    end
  end

  // Reference model: what EX holds, whether a load is outstanding,
  // whether a flush arrived during the wait, and stall cycles so far.
  logic [CW-1:0] m_ctrl = '0;
  logic [DW-1:0] m_data = '0;
  logic          m_ld   = 1'b0;
  logic          m_fp   = 1'b0;
  int            m_cnt  = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step();
    logic stall_e;
    logic kill;
    if (!rst_n) begin
      m_ctrl = '0; m_data = '0; m_ld = 1'b0; m_fp = 1'b0; m_cnt = 0;
      exp_q.push_back('0);
      return;
    end
    stall_e = m_ld && !dm;
    exp_q.push_back({m_ctrl, m_data, stall_e, m_ld, 16'(sat(m_cnt, 65535)), 4'(sat(m_cnt, 15))});
    if (stall_e) m_cnt++;
    if (!m_ld || dm) begin
      kill   = flush || m_fp;
      m_ctrl = kill ? '0 : in_ctrl;
      m_data = kill ? '0 : in_data;
      m_ld   = in_ctrl[18] && !kill;
      m_fp   = 1'b0;
    end else if (flush) begin
      m_fp = 1'b1;
    end
  endtask

  // driver
  task automatic cycle(input logic r, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic f, input logic v);
    @(posedge clk);
    #1;
    rst_n = r; in_ctrl = c; in_data = d; flush = f; dm = v;
    model_step();
  endtask

  function automatic logic [CW-1:0] mk_ctrl(input logic rw, input logic ld, input logic st,
                                            input logic [3:0] alu, input logic [2:0] f3,
                                            input logic [4:0] rd);
    return {rw, 1'b0, 1'b0, ld, st, 1'b0, 1'b0, 1'b0, alu, (ld ? 2'b01 : 2'b00), f3, rd};
  endfunction

  initial begin
    logic [CW-1:0] nop, add, lw, sw, rc;
    logic [DW-1:0] d_add, d_lw, d_sw, d0, rd_d;
    nop   = '0;
    add   = mk_ctrl(1'b1, 1'b0, 1'b0, 4'b0000, 3'b000, 5'd5);
    lw    = mk_ctrl(1'b1, 1'b1, 1'b0, 4'b0000, 3'b010, 5'd7);
    sw    = mk_ctrl(1'b0, 1'b0, 1'b1, 4'b0000, 3'b010, 5'd0);
    d0    = '0;
    d_add = {32'h0000_0100, 32'h0000_0010, 32'h0000_0020, 32'h0000_0000};
    d_lw  = {32'h0000_0104, 32'h0000_1000, 32'h0000_0000, 32'h0000_0008};
    d_sw  = {32'h0000_0108, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0000_0004};

    // reset
    repeat (3) cycle(1'b0, nop, d0, 1'b0, 1'b0);
    // R-type add
    cycle(1'b1, add, d_add, 1'b0, 1'b0);
    cycle(1'b1, nop, d0, 1'b0, 1'b1);
    // load with three wait cycles, then add accepted on dm_valid
    cycle(1'b1, lw, d_lw, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, add, d_add, 1'b0, 1'b0);
    cycle(1'b1, add, d_add, 1'b0, 1'b1);
    cycle(1'b1, nop, d0, 1'b0, 1'b0);
    // flush kills a store
    cycle(1'b1, sw, d_sw, 1'b1, 1'b0);
    cycle(1'b1, nop, d0, 1'b0, 1'b0);
    // flush in wait cycle 2, data in cycle 4
    cycle(1'b1, lw, d_lw, 1'b0, 1'b0);
    cycle(1'b1, add, d_add, 1'b0, 1'b0);
    cycle(1'b1, add, d_add, 1'b1, 1'b0);
    cycle(1'b1, add, d_add, 1'b0, 1'b0);
    cycle(1'b1, add, d_add, 1'b0, 1'b1);
    cycle(1'b1, nop, d0, 1'b0, 1'b0);
    // data already valid in the first wait cycle
    cycle(1'b1, lw, d_lw, 1'b0, 1'b1);
    cycle(1'b1, add, d_add, 1'b0, 1'b1);
    cycle(1'b1, nop, d0, 1'b0, 1'b0);
    // back-to-back loads
    cycle(1'b1, lw, d_lw, 1'b0, 1'b0);
    cycle(1'b1, lw, d_sw, 1'b0, 1'b1);
    cycle(1'b1, add, d_add, 1'b0, 1'b0);
    cycle(1'b1, add, d_add, 1'b0, 1'b1);
    // flush and dm_valid together
    cycle(1'b1, lw, d_lw, 1'b0, 1'b0);
    cycle(1'b1, lw, d_lw, 1'b1, 1'b1);
    cycle(1'b1, nop, d0, 1'b0, 1'b0);
    // 4-bit counter saturation
    cycle(1'b1, lw, d_lw, 1'b0, 1'b0);
    repeat (20) cycle(1'b1, add, d_add, 1'b0, 1'b0);
    cycle(1'b1, add, d_add, 1'b0, 1'b1);
    cycle(1'b1, nop, d0, 1'b0, 1'b0);
    // reset in the middle of a load wait
    cycle(1'b1, lw, d_lw, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, add, d_add, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, add, d_add, 1'b0, 1'b0);
    cycle(1'b1, add, d_add, 1'b0, 1'b0);
    cycle(1'b1, nop, d0, 1'b0, 1'b0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      rc     = CW'($urandom);
      rc[18] = ($urandom_range(0, 3) == 0);
      rd_d   = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'b1, rc, rd_d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
    end

    @(negedge clk);
    #1;
    check("queue_drained", DW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
